sample_feeder: RTL

Multi-stream input feeder for the polyphase resampling filter. It buffers interleaved upstream samples in a circular FIFO and answers the filter's input request with a registered acknowledge and data word. It sits between the sample producer (testbench source or audio front-end) and the filter's req_in/ack_in/data_in port. It also enforces stream ordering and reports underruns.

---
 rtl/sample_feeder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sample_feeder.sv
// Input feeder for the polyphase resampler: a registered head word plus a small
// circular FIFO, with stream-order enforcement and underrun accounting.
module sample_feeder #(
    parameter int DWIDTH         = 16,
    parameter int DEPTH          = 16,
    parameter int DEPTH_LOG      = 4,
    parameter int NR_STREAMS     = 1024,
    parameter int NR_STREAMS_LOG = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DWIDTH-1:0]         wr_data,
    input  logic [NR_STREAMS_LOG-1:0] wr_stream,
    output logic                      full,
    input  logic                      req,
    output logic                      ack,
    output logic [DWIDTH-1:0]         data,
    output logic [NR_STREAMS_LOG-1:0] cur_stream,
    output logic [DEPTH_LOG:0]        level,
    output logic                      order_err,
    output logic [15:0]               underrun_cnt
);
    localparam int FDEPTH = DEPTH - 1;
    localparam logic [DEPTH_LOG-1:0] PTR_LAST = DEPTH_LOG'(FDEPTH - 1);

    logic [DWIDTH-1:0]         r_mem [FDEPTH];
    logic [DEPTH_LOG-1:0]      r_rd_ptr;
    logic [DEPTH_LOG-1:0]      r_wr_ptr;
    logic [DEPTH_LOG-1:0]      r_fifo_cnt;
    logic                      r_ack;
    logic [DWIDTH-1:0]         r_data;
    logic [NR_STREAMS_LOG-1:0] r_cur;
    logic [NR_STREAMS_LOG-1:0] r_exp;
    logic                      r_order_err;
    logic                      r_started;
    logic [15:0]               r_underrun;

    logic                      w_xfer;
    logic                      w_fifo_empty;
    logic                      w_full;
    logic                      w_wr_ok;
    logic                      w_bad_tag;
    logic                      w_bypass;
    logic                      w_push;
    logic                      w_pop;
    logic [DEPTH_LOG:0]        w_level;

    // Occupancy counts the head word too, so full only depends on registered state.
    assign w_level      = {1'b0, r_fifo_cnt} + {{DEPTH_LOG{1'b0}}, r_ack};
    assign w_full       = (w_level == (DEPTH_LOG+1)'(DEPTH));
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_xfer       = req && r_ack;
    assign w_wr_ok      = wr_en && !w_full && (wr_stream == r_exp);
    assign w_bad_tag    = wr_en && !w_full && (wr_stream != r_exp);
    assign w_bypass     = w_wr_ok && (!r_ack || (w_xfer && w_fifo_empty));
    assign w_push       = w_wr_ok && !w_bypass;
    assign w_pop        = w_xfer && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            else if (w_pop && !w_push)
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
        end
    end

    // Head refill: FIFO front first, then a bypassed write; otherwise the head drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_data <= '0;
            r_cur  <= '0;
        end else begin
            if (w_pop) begin
                r_data <= r_mem[r_rd_ptr];
                r_ack  <= 1'b1;
            end else if (w_bypass) begin
                r_data <= wr_data;
                r_ack  <= 1'b1;
            end else if (w_xfer) begin
                r_ack  <= 1'b0;
            end
            if (w_xfer)
                r_cur <= r_cur + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp       <= '0;
            r_order_err <= 1'b0;
            r_started   <= 1'b0;
            r_underrun  <= '0;
        end else begin
            if (w_wr_ok)
                r_exp <= r_exp + 1'b1;
            if (w_bad_tag)
                r_order_err <= 1'b1;
            if (w_xfer)
                r_started <= 1'b1;
            if (r_started && req && !r_ack && (r_underrun != 16'hFFFF))
                r_underrun <= r_underrun + 1'b1;
        end
    end

    assign full         = w_full;
    assign ack          = r_ack;
    assign data         = r_data;
    assign cur_stream   = r_cur;
    assign level        = w_level;
    assign order_err    = r_order_err;
    assign underrun_cnt = r_underrun;
endmodule
